// File: rtl/uart_tx_fifo_if.sv
// Host push port and uart_tx request port of the transmit FIFO.
// The master drives pushes and the uart_tx busy line; the slave is the FIFO.
interface uart_tx_fifo_if #(
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 16
);
  logic [7:0]       wr_data;
  logic             wr_en;
  logic             ovf_clr;
  logic             full;
  logic             empty;
  logic [ADDR_W:0]  level;
  logic             overflow;
  logic [7:0]       tx_data;
  logic             tx_start;
  logic             tx_busy;
  logic [CNT_W-1:0] frames_sent;

  modport master (
    output wr_data,
    output wr_en,
    output ovf_clr,
    output tx_busy,
    input  full,
    input  empty,
    input  level,
    input  overflow,
    input  tx_data,
    input  tx_start,
    input  frames_sent
  );

  modport slave (
    input  wr_data,
    input  wr_en,
    input  ovf_clr,
    input  tx_busy,
    output full,
    output empty,
    output level,
    output overflow,
    output tx_data,
    output tx_start,
    output frames_sent
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding uart_tx: pops one byte per frame, holds the request
// until the synchronized busy rises, and counts completed frames.
module uart_tx_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 16
) (
  input logic           clk,
  input logic           reset,
  uart_tx_fifo_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_DONE
  } state_e;

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  logic [7:0]       mem_q [DEPTH];
  logic [ADDR_W:0]  wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]  rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]  level;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  state_e           state_q, state_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_start_q, tx_start_d;
  logic [CNT_W-1:0] frames_q, frames_d;
  logic             ovf_q, ovf_d;
  logic             busy_m_q;
  logic             busy_s_q;

  // Extra wrap bit makes the pointer difference the exact occupancy.
  assign level = wr_ptr_q - rd_ptr_q;
  assign full  = (level == DEPTH_L);
  assign empty = (level == '0);
  assign push  = bus.wr_en & ~full;

  always_comb begin
    state_d    = state_q;
    tx_data_d  = tx_data_q;
    tx_start_d = tx_start_q;
    frames_d   = frames_q;
    rd_ptr_d   = rd_ptr_q;
    pop        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          tx_data_d  = mem_q[rd_ptr_q[ADDR_W-1:0]];
          rd_ptr_d   = rd_ptr_q + 1'b1;
          tx_start_d = 1'b1;
          state_d    = REQ;
        end
      end
      REQ: begin
        if (busy_s_q) begin
          tx_start_d = 1'b0;
          state_d    = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (!busy_s_q) begin
          frames_d = frames_q + 1'b1;
          state_d  = IDLE;
        end
      end
      default: begin
        tx_start_d = 1'b0;
        state_d    = IDLE;
      end
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
  end

  // Set beats clear when a dropped push meets ovf_clr.
  always_comb begin
    ovf_d = ovf_q;
    if (bus.ovf_clr) begin
      ovf_d = 1'b0;
    end
    if (bus.wr_en && full) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[ADDR_W-1:0]] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      state_q    <= IDLE;
      tx_data_q  <= 8'h00;
      tx_start_q <= 1'b0;
      frames_q   <= '0;
      ovf_q      <= 1'b0;
      busy_m_q   <= 1'b0;
      busy_s_q   <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      state_q    <= state_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      frames_q   <= frames_d;
      ovf_q      <= ovf_d;
      busy_m_q   <= bus.tx_busy;
      busy_s_q   <= busy_m_q;
    end
  end

  assign bus.full        = full;
  assign bus.empty       = empty;
  assign bus.level       = level;
  assign bus.overflow    = ovf_q;
  assign bus.tx_data     = tx_data_q;
  assign bus.tx_start    = tx_start_q;
  assign bus.frames_sent = frames_q;

endmodule
